// File: rtl/frame_scheduler_pkg.sv
// Shared types for the per-frame step/draw scheduler:
// FSM state encoding and field memory owner codes.
package frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SIM_GO    = 3'd1,
    ST_SIM_WAIT  = 3'd2,
    ST_DRAW_GO   = 3'd3,
    ST_DRAW_WAIT = 3'd4,
    ST_SWAP      = 3'd5
  } state_t;

  localparam logic OWNER_SIM  = 1'b0;
  localparam logic OWNER_DRAW = 1'b1;

endpackage

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: fluid step, then draw, then buffer swap,
// with dropped-tick accounting and a wait-state watchdog.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FRAME_CNTW     = 16,
  parameter int OVR_CNTW       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_tick,
  output logic                  sim_start,
  input  logic                  sim_done,
  output logic                  draw_start,
  input  logic                  draw_done,
  output logic                  field_owner,
  output logic                  buf_sel,
  output logic                  busy,
  output logic [FRAME_CNTW-1:0] frame_count,
  output logic [OVR_CNTW-1:0]   overrun_count,
  output logic                  timeout_err
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Strobes and grants decode straight from the state register.
  assign sim_start   = (state == ST_SIM_GO);
  assign draw_start  = (state == ST_DRAW_GO);
  assign busy        = (state != ST_IDLE);
  assign field_owner = (state == ST_DRAW_GO ||
                        state == ST_DRAW_WAIT) ?
                       OWNER_DRAW : OWNER_SIM;

  // Frame sequencing, watchdog, swap and dropped-tick counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      buf_sel       <= 1'b0;
      frame_count   <= '0;
      overrun_count <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if (frame_tick && state != ST_IDLE &&
          overrun_count != '1)
        overrun_count <= overrun_count + 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (enable && frame_tick)
            state <= ST_SIM_GO;
        end
        ST_SIM_GO: begin
          wait_cnt <= '0;
          state    <= ST_SIM_WAIT;
        end
        ST_SIM_WAIT: begin
          if (sim_done) begin
            state <= ST_DRAW_GO;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DRAW_GO: begin
          wait_cnt <= '0;
          state    <= ST_DRAW_WAIT;
        end
        ST_DRAW_WAIT: begin
          if (draw_done) begin
            state <= ST_SWAP;
          end else if (wait_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_SWAP: begin
          buf_sel     <= ~buf_sel;
          frame_count <= frame_count + 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, max cycles allowed in any wait state before abort.
REQ-002 Parameter FRAME_CNTW, default 16, width of frame counter.
REQ-003 Parameter OVR_CNTW, default 8, width of overrun counter.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port enable  input  1  permits new frames to begin.
REQ-007 Port frame_tick  input  1  one-cycle pulse per display frame (vblank).
REQ-008 Port sim_start  output  1  one-cycle start pulse to fluid step engine.
REQ-009 Port sim_done  input  1  step engine completion pulse.
REQ-010 Port draw_start  output  1  one-cycle start pulse to draw_blocks.
REQ-011 Port draw_done  input  1  draw_blocks completion pulse.
REQ-012 Port field_owner  output  1  field memory grant: 0 = step engine, 1 = draw_blocks.
REQ-013 Port buf_sel  output  1  selects framebuffer being drawn; display reads ~buf_sel.
REQ-014 Port busy  output  1  high whenever state is not IDLE.
REQ-015 Port frame_count  output  FRAME_CNTW  completed-frame count.
REQ-016 Port overrun_count  output  OVR_CNTW  dropped-tick count.
REQ-017 Port timeout_err  output  1  sticky watchdog abort flag.

Function
REQ-018 FSM states: IDLE, SIM_GO, SIM_WAIT, DRAW_GO, DRAW_WAIT, SWAP; outputs decoded from registered state only.
REQ-019 IDLE -> SIM_GO when enable and frame_tick sampled high; else remain IDLE.
REQ-020 SIM_GO lasts exactly one cycle, sim_start high only there, then SIM_WAIT.
REQ-021 SIM_WAIT -> DRAW_GO on sim_done; DRAW_GO lasts one cycle, draw_start high only there, then DRAW_WAIT.
REQ-022 DRAW_WAIT -> SWAP on draw_done; SWAP lasts one cycle, then IDLE.
REQ-023 Latency: tick sampled at edge t gives sim_start during cycle t+1; done sampled at edge u gives next start/SWAP during cycle u+1.
REQ-024 At SWAP exit, buf_sel toggles and frame_count increments, wrapping modulo 2^FRAME_CNTW.
REQ-025 field_owner = 1 in DRAW_GO and DRAW_WAIT, 0 in all other states.
REQ-026 sim_done/draw_done are ignored outside their own wait state, including a done coincident with the start pulse.
REQ-027 frame_tick while not IDLE (including SWAP) is dropped; overrun_count increments, saturating at all-ones.
REQ-028 frame_tick while IDLE with enable low is ignored and not counted.
REQ-029 enable deassert mid-frame does not abort; current frame completes through SWAP.
REQ-030 Wait counter clears on entering SIM_WAIT or DRAW_WAIT; reaching TIMEOUT_CYCLES-1 without done sets timeout_err and returns to IDLE with no swap and no frame_count change.
REQ-031 timeout_err cleared only by rst; scheduler keeps operating after it is set.

Reset
REQ-032 rst in any state forces IDLE next cycle, aborting any frame without swap.
REQ-033 Reset values: sim_start 0, draw_start 0, field_owner 0, buf_sel 0, busy 0, frame_count 0, overrun_count 0, timeout_err 0, wait counter 0.
REQ-034 frame_tick coincident with rst is discarded.

Structure
REQ-035 Shared package holds the state enum type and field_owner encodings (OWNER_SIM, OWNER_DRAW).
REQ-036 Single module; watchdog counter is inline, no sub-modules.

Verification
REQ-037 rst, enable=1, tick at t, sim_done 5 cycles after sim_start, draw_done 10 after draw_start -> sim_start at t+1, draw_start one cycle after sim_done, buf_sel=1, frame_count=1, busy low afterwards.
REQ-038 Three ticks during DRAW_WAIT plus one in SWAP -> overrun_count=4, no extra sim_start; OVR_CNTW=2 with 5 drops -> saturates at 3.
REQ-039 draw_done asserted in DRAW_GO only -> ignored, remains DRAW_WAIT; sim_done during DRAW_WAIT -> no effect.
REQ-040 TIMEOUT_CYCLES=16, sim_done withheld -> timeout_err=1 after 16 wait cycles, IDLE, buf_sel and frame_count unchanged; next tick runs full frame normally.
REQ-041 rst asserted in DRAW_WAIT -> IDLE, field_owner=0, all outputs at reset values; enable dropped in SIM_WAIT -> frame completes, next tick ignored.
